mp_completion_monitor: RTL

// Synthesizable run/completion monitor for the multiprocessor system, generalised to N cores.

---
 rtl/mp_mon_pkg.sv | 14 +
 rtl/mp_completion_monitor_if.sv | 36 +++
 rtl/mp_core_tracker.sv | 35 +++
 rtl/mp_completion_monitor.sv | 88 ++++++++
 4 files changed

// File: rtl/mp_mon_pkg.sv
// Shared types and width helpers for the multiprocessor completion monitor.
package mp_mon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} mon_state_e;

    function automatic int cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    function automatic int id_w(input int n_cores);
        return (n_cores > 1) ? $clog2(n_cores) : 1;
    endfunction

endpackage

// File: rtl/mp_completion_monitor_if.sv
// Control, per-core status and readout bundle between a run controller and the monitor.
interface mp_completion_monitor_if import mp_mon_pkg::*; #(
    parameter int N_CORES        = 3,
    parameter int TIMEOUT_CYCLES = 400
) ();
    localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
    localparam int ID_W  = id_w(N_CORES);

    logic               start;
    logic               abort;
    logic [N_CORES-1:0] core_done;
    logic [N_CORES-1:0] core_pass;
    logic [ID_W-1:0]    rd_idx;
    logic               busy;
    logic               all_done;
    logic               all_pass;
    logic               timeout;
    logic [N_CORES-1:0] done_mask;
    logic [N_CORES-1:0] pass_mask;
    logic               fail_valid;
    logic [ID_W-1:0]    first_fail_id;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   rd_cycles;

    modport master (
        output start, abort, core_done, core_pass, rd_idx,
        input  busy, all_done, all_pass, timeout, done_mask, pass_mask,
               fail_valid, first_fail_id, cycle_count, rd_cycles
    );

    modport slave (
        input  start, abort, core_done, core_pass, rd_idx,
        output busy, all_done, all_pass, timeout, done_mask, pass_mask,
               fail_valid, first_fail_id, cycle_count, rd_cycles
    );
endinterface

// File: rtl/mp_core_tracker.sv
// Per-core completion record: sticky done flag, pass sampled at first done, completion cycle.
module mp_core_tracker #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             core_done,
    input  logic             core_pass,
    input  logic [CNT_W-1:0] cycle,
    output logic             done,
    output logic             pass,
    output logic             new_done,
    output logic [CNT_W-1:0] latency
);
    assign new_done = sample_en & core_done & ~done;

    // clear beats sample so an abort/start edge never leaves a stale record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            latency <= '0;
        end else if (clear) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            latency <= '0;
        end else if (new_done) begin
            done    <= 1'b1;
            pass    <= core_pass;
            latency <= cycle;
        end
    end
endmodule

// File: rtl/mp_completion_monitor.sv
// Bounded run-window monitor: per-core completion tracking, aggregate status and fail priority.
module mp_completion_monitor import mp_mon_pkg::*; #(
    parameter int N_CORES        = 3,
    parameter int TIMEOUT_CYCLES = 400
) (
    input logic                    clk,
    input logic                    rst_n,
    mp_completion_monitor_if.slave mon
);
    localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
    localparam int ID_W  = id_w(N_CORES);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

    mon_state_e                    state;
    logic [CNT_W-1:0]              cycle_count, cnt_nxt;
    logic [N_CORES-1:0]            done_q, pass_q, new_done, new_fail;
    logic [N_CORES-1:0][CNT_W-1:0] lat_q;
    logic                          fail_valid, run, clear, done_all;
    logic [ID_W-1:0]               first_fail_id, ff_id;

    assign run      = (state == RUN);
    assign clear    = mon.abort | (mon.start & ~run);
    assign cnt_nxt  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    assign done_all = &(done_q | new_done);
    assign new_fail = new_done & ~mon.core_pass;

    for (genvar i = 0; i < N_CORES; i++) begin : g_trk
        mp_core_tracker #(.CNT_W(CNT_W)) u_trk (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .sample_en(run),
            .core_done(mon.core_done[i]),
            .core_pass(mon.core_pass[i]),
            .cycle    (cnt_nxt),
            .done     (done_q[i]),
            .pass     (pass_q[i]),
            .new_done (new_done[i]),
            .latency  (lat_q[i])
        );
    end

    // lowest index wins among cores failing in the same cycle
    always_comb begin
        ff_id = '0;
        for (int i = N_CORES - 1; i >= 0; i--)
            if (new_fail[i]) ff_id = ID_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cycle_count   <= '0;
            fail_valid    <= 1'b0;
            first_fail_id <= '0;
        end else if (mon.abort) begin
            state         <= IDLE;
            cycle_count   <= '0;
            fail_valid    <= 1'b0;
            first_fail_id <= '0;
        end else if (run) begin
            cycle_count <= cnt_nxt;
            if (!fail_valid && |new_fail) begin
                fail_valid    <= 1'b1;
                first_fail_id <= ff_id;
            end
            // completion is checked first so a last-done on the final cycle reports DONE
            if (done_all)              state <= DONE;
            else if (cnt_nxt == TO_CNT) state <= TIMEOUT;
        end else if (mon.start) begin
            state         <= RUN;
            cycle_count   <= '0;
            fail_valid    <= 1'b0;
            first_fail_id <= '0;
        end
    end

    assign mon.busy          = run;
    assign mon.all_done      = (state == DONE);
    assign mon.all_pass      = (state == DONE) & (&pass_q);
    assign mon.timeout       = (state == TIMEOUT);
    assign mon.done_mask     = done_q;
    assign mon.pass_mask     = pass_q;
    assign mon.fail_valid    = fail_valid;
    assign mon.first_fail_id = first_fail_id;
    assign mon.cycle_count   = cycle_count;
    assign mon.rd_cycles     = (int'(mon.rd_idx) < N_CORES) ? lat_q[mon.rd_idx] : '0;
endmodule
